// File: rtl/arb_pkg.sv
// Shared definitions for the memory bus arbiter and its round-robin picker.
package arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int REQ_FETCH  = 0;
  localparam int REQ_LDST   = 1;
  localparam int REQ_LOADER = 2;

  // Watchdog counter width; a disabled watchdog still gets a 1-bit counter.
  function automatic int cntWidth(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: the search starts one past the last winner and wraps,
// so every active requester is served within N_REQ grants.
module rr_picker #(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  // Walk the requesters from ptr+1 round to ptr itself; the first hit wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      w_cand = IDX_W'((int'(i_ptr) + off) % N_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: latches one requester's transaction onto the shared bus,
// waits for the memory strobe (or the watchdog), then reports completion.
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0]        i_we,
  input  logic [N_REQ*ADDR_W-1:0] i_addr,
  input  logic [N_REQ*DATA_W-1:0] i_wdata,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [N_REQ-1:0]        o_dv,
  output logic [N_REQ-1:0]        o_err,
  output logic [DATA_W-1:0]       o_rdata,
  output logic                    o_bus_req,
  output logic                    o_bus_we,
  output logic [ADDR_W-1:0]       o_bus_addr,
  output logic [DATA_W-1:0]       o_bus_wdata,
  input  logic                    i_bus_DV,
  input  logic [DATA_W-1:0]       i_bus_rdata
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = cntWidth(TIMEOUT);
  // r_cnt counts BUSY cycles already spent without a strobe, so the cycle in
  // which it equals TIMEOUT-1 is the TIMEOUT-th BUSY cycle and the last one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_t             r_state;
  state_t             w_stateNext;
  logic [IDX_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_dv;
  logic [N_REQ-1:0]   r_err;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_busReq;
  logic               r_busWe;
  logic [ADDR_W-1:0]  r_busAddr;
  logic [DATA_W-1:0]  r_busWdata;

  logic [N_REQ-1:0]   w_pickGnt;
  logic [IDX_W-1:0]   w_pickIdx;
  logic               w_timeout;
  logic [IDX_W-1:0]   w_ptrNext;
  logic [CNT_W-1:0]   w_cntNext;
  logic [N_REQ-1:0]   w_gntNext;
  logic [N_REQ-1:0]   w_dvNext;
  logic [N_REQ-1:0]   w_errNext;
  logic [DATA_W-1:0]  w_rdataNext;
  logic               w_busReqNext;
  logic               w_busWeNext;
  logic [ADDR_W-1:0]  w_busAddrNext;
  logic [DATA_W-1:0]  w_busWdataNext;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pickGnt),
    .o_idx (w_pickIdx)
  );

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  // State register; reset from any state abandons the transaction silently.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_stateNext;
  end

  // Next state: a strobe beats a simultaneous watchdog expiry, DONE always returns to IDLE.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: if (|i_req) w_stateNext = ST_BUSY;
      ST_BUSY: if (i_bus_DV || w_timeout) w_stateNext = ST_DONE;
      ST_DONE: w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; bus fields only move when a grant is taken.
  always_comb begin
    w_ptrNext      = r_ptr;
    w_cntNext      = r_cnt;
    w_gntNext      = r_gnt;
    w_dvNext       = '0;
    w_errNext      = '0;
    w_rdataNext    = r_rdata;
    w_busReqNext   = r_busReq;
    w_busWeNext    = r_busWe;
    w_busAddrNext  = r_busAddr;
    w_busWdataNext = r_busWdata;
    case (r_state)
      ST_IDLE: begin
        w_gntNext = '0;
        if (|i_req) begin
          w_gntNext      = w_pickGnt;
          w_ptrNext      = w_pickIdx;
          w_cntNext      = '0;
          w_busReqNext   = 1'b1;
          w_busWeNext    = i_we[w_pickIdx];
          w_busAddrNext  = i_addr[int'(w_pickIdx)*ADDR_W +: ADDR_W];
          w_busWdataNext = i_wdata[int'(w_pickIdx)*DATA_W +: DATA_W];
        end
      end
      ST_BUSY: begin
        if (i_bus_DV) begin
          w_rdataNext  = i_bus_rdata;
          w_busReqNext = 1'b0;
          w_dvNext     = r_gnt;
        end else if (w_timeout) begin
          w_busReqNext = 1'b0;
          w_errNext    = r_gnt;
        end else begin
          w_cntNext = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        end
      end
      ST_DONE: w_gntNext = '0;
      default: w_gntNext = '0;
    endcase
  end

  // Datapath and output registers; ptr resets to the last index so requester 0 wins first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr      <= IDX_W'(N_REQ - 1);
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_dv       <= '0;
      r_err      <= '0;
      r_rdata    <= '0;
      r_busReq   <= 1'b0;
      r_busWe    <= 1'b0;
      r_busAddr  <= '0;
      r_busWdata <= '0;
    end else begin
      r_ptr      <= w_ptrNext;
      r_cnt      <= w_cntNext;
      r_gnt      <= w_gntNext;
      r_dv       <= w_dvNext;
      r_err      <= w_errNext;
      r_rdata    <= w_rdataNext;
      r_busReq   <= w_busReqNext;
      r_busWe    <= w_busWeNext;
      r_busAddr  <= w_busAddrNext;
      r_busWdata <= w_busWdataNext;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_dv        = r_dv;
  assign o_err       = r_err;
  assign o_rdata     = r_rdata;
  assign o_bus_req   = r_busReq;
  assign o_bus_we    = r_busWe;
  assign o_bus_addr  = r_busAddr;
  assign o_bus_wdata = r_busWdata;

endmodule
